// File: rtl/text_console_writer_pkg.sv
// text_console_writer_pkg: shared 80x30 text-screen geometry, control codes, FSM states and cell addressing.
package text_console_writer_pkg;
    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int AW   = 20;
    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PUT      = 3'd1;
    localparam logic [2:0] S_SCROLL   = 3'd2;
    localparam logic [2:0] S_CLR_LINE = 3'd3;
    localparam logic [2:0] S_CLR_ALL  = 3'd4;
    typedef enum logic {MV_COPY, MV_FILL} mv_mode_e;
    function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
        return AW'(row) * AW'(COLS) + AW'(col);
    endfunction
endpackage

// File: rtl/text_console_writer_if.sv
// text_console_writer_if: byte-stream input, VRAM ports and cursor/busy status of the console writer.
interface text_console_writer_if;
    logic [7:0] char_in;
    logic char_valid;
    logic char_ready;
    logic vram_we;
    logic [text_console_writer_pkg::AW-1:0] vram_waddr;
    logic [text_console_writer_pkg::AW-1:0] vram_raddr;
    logic [7:0] vram_wdata;
    logic [7:0] vram_rdata;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;
    logic busy;
    modport master (
        output char_in, char_valid, vram_rdata,
        input  char_ready, vram_we, vram_waddr, vram_raddr, vram_wdata, cursor_row, cursor_col, busy
    );
    modport slave (
        input  char_in, char_valid, vram_rdata,
        output char_ready, vram_we, vram_waddr, vram_raddr, vram_wdata, cursor_row, cursor_col, busy
    );
endinterface

// File: rtl/vram_block_mover.sv
// vram_block_mover: one-cell-per-cycle VRAM copy (read ahead by one cycle) or constant fill engine.
module vram_block_mover
    import text_console_writer_pkg::*;
(
    input  logic clk,
    input  logic clrn,
    input  logic start_i,
    input  mv_mode_e mode_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [11:0] len_i,
    input  logic [7:0] fill_i,
    input  logic [7:0] rdata_i,
    output logic we_o,
    output logic [AW-1:0] waddr_o,
    output logic [AW-1:0] raddr_o,
    output logic [7:0] wdata_o,
    output logic done_o
);
    logic copy_q, rd_q, we_q;
    logic [11:0] cnt_q;
    logic [AW-1:0] waddr_q, raddr_q;
    logic [7:0] wdata_q;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            copy_q  <= 1'b0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
        end else if (start_i) begin
            copy_q  <= mode_i == MV_COPY;
            rd_q    <= mode_i == MV_COPY;
            we_q    <= mode_i == MV_FILL;
            cnt_q   <= len_i - 12'd1;
            waddr_q <= dst_i;
            raddr_q <= src_i;
            wdata_q <= fill_i;
        end else if (copy_q) begin
            we_q    <= rd_q;
            waddr_q <= waddr_q + AW'(we_q);
            if (rd_q) begin
                rd_q    <= cnt_q != 12'd0;
                cnt_q   <= cnt_q - 12'(cnt_q != 12'd0);
                raddr_q <= raddr_q + AW'(cnt_q != 12'd0);
            end
        end else if (we_q) begin
            we_q    <= cnt_q != 12'd0;
            cnt_q   <= cnt_q - 12'(cnt_q != 12'd0);
            waddr_q <= waddr_q + AW'(cnt_q != 12'd0);
        end
    end
    // Copy writes forward the RAM's registered read data so each cell lands one cycle after its read.
    assign wdata_o = copy_q ? rdata_i : wdata_q;
    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign raddr_o = raddr_q;
    assign done_o  = we_q & (copy_q ? !rd_q : cnt_q == 12'd0);
endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream handshake, cursor tracking and control-code FSM driving the VRAM mover.
module text_console_writer
    import text_console_writer_pkg::*;
(
    input logic clk,
    input logic clrn,
    text_console_writer_if.slave bus
);
    logic [2:0] state_q, state_d;
    logic [4:0] row_q, row_d;
    logic [6:0] col_q, col_d;
    logic pend_q, pend_d, ready_q, busy_q;
    logic accept, bottom, last_col, go_scroll;
    logic mv_start, mv_done;
    mv_mode_e mv_mode;
    logic [AW-1:0] mv_src, mv_dst;
    logic [11:0] mv_len;
    logic [7:0] mv_fill;
    assign accept   = ready_q & bus.char_valid;
    assign bottom   = row_q == 5'(ROWS - 1);
    assign last_col = col_q == 7'(COLS - 1);
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        pend_d    = pend_q;
        go_scroll = 1'b0;
        mv_start  = 1'b0;
        mv_mode   = MV_FILL;
        mv_src    = '0;
        mv_dst    = cell_addr(row_q, col_q);
        mv_len    = 12'd1;
        mv_fill   = bus.char_in;
        case (state_q)
            S_IDLE: if (accept) begin
                if (bus.char_in >= 8'h20) begin
                    mv_start = 1'b1;
                    state_d  = S_PUT;
                    col_d    = last_col ? 7'd0 : col_q + 7'd1;
                    row_d    = (last_col && !bottom) ? row_q + 5'd1 : row_q;
                    pend_d   = last_col && bottom;
                end else if (bus.char_in == LF) begin
                    col_d     = 7'd0;
                    row_d     = bottom ? row_q : row_q + 5'd1;
                    go_scroll = bottom;
                end else if (bus.char_in == CR) begin
                    col_d = 7'd0;
                end else if (bus.char_in == BS && col_q != 7'd0) begin
                    col_d    = col_q - 7'd1;
                    mv_start = 1'b1;
                    mv_dst   = cell_addr(row_q, col_q - 7'd1);
                    mv_fill  = BLANK;
                    state_d  = S_PUT;
                end else if (bus.char_in == FF) begin
                    row_d    = 5'd0;
                    col_d    = 7'd0;
                    mv_start = 1'b1;
                    mv_dst   = '0;
                    mv_len   = 12'(ROWS * COLS);
                    mv_fill  = BLANK;
                    state_d  = S_CLR_ALL;
                end
            end
            // A bottom-row wrap finishes its character write before the scroll starts.
            S_PUT: if (mv_done) begin
                pend_d    = 1'b0;
                go_scroll = pend_q;
                state_d   = S_IDLE;
            end
            S_SCROLL: if (mv_done) begin
                mv_start = 1'b1;
                mv_dst   = AW'((ROWS - 1) * COLS);
                mv_len   = 12'(COLS);
                mv_fill  = BLANK;
                state_d  = S_CLR_LINE;
            end
            default: if (mv_done) state_d = S_IDLE;
        endcase
        if (go_scroll) begin
            mv_start = 1'b1;
            mv_mode  = MV_COPY;
            mv_src   = AW'(COLS);
            mv_dst   = '0;
            mv_len   = 12'((ROWS - 1) * COLS);
            state_d  = S_SCROLL;
        end
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pend_q  <= pend_d;
            ready_q <= state_d == S_IDLE;
            busy_q  <= state_d == S_SCROLL || state_d == S_CLR_LINE || state_d == S_CLR_ALL;
        end
    end
    vram_block_mover u_mover (
        .clk(clk),
        .clrn(clrn),
        .start_i(mv_start),
        .mode_i(mv_mode),
        .src_i(mv_src),
        .dst_i(mv_dst),
        .len_i(mv_len),
        .fill_i(mv_fill),
        .rdata_i(bus.vram_rdata),
        .we_o(bus.vram_we),
        .waddr_o(bus.vram_waddr),
        .raddr_o(bus.vram_raddr),
        .wdata_o(bus.vram_wdata),
        .done_o(mv_done)
    );
    assign bus.char_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.cursor_row = row_q;
    assign bus.cursor_col = col_q;
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: random and directed bytes against a screen-level reference model and a VRAM model.
module tb_text_console_writer;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cyc = 0;
    int viol = 0;
    int acc_cyc = 0;
    int mr = 0;
    int mc = 0;
    int lg_cyc[$];
    int lg_addr[$];
    int lg_data[$];
    logic [7:0] mem [0:4095];
    logic [7:0] scr [0:2399];
    logic [7:0] pre [0:2399];
    always #5 clk = ~clk;
    text_console_writer_if bus();
    text_console_writer dut (.clk(clk), .clrn(clrn), .bus(bus));
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.vram_we) mem[bus.vram_waddr[11:0]] <= bus.vram_wdata;
        bus.vram_rdata <= mem[bus.vram_raddr[11:0]];
    end
    always @(negedge clk) if (clrn) begin
        if (bus.vram_we) begin
            lg_cyc.push_back(cyc);
            lg_addr.push_back(int'(bus.vram_waddr));
            lg_data.push_back(int'(bus.vram_wdata));
        end
        if (bus.busy) busy_cyc++;
        if (bus.busy && bus.char_ready) viol++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_scroll();
        for (int i = 0; i < 2320; i++) scr[i] = scr[i + 80];
        for (int i = 2320; i < 2400; i++) scr[i] = 8'h20;
    endtask
    task automatic model_char(input logic [7:0] c);
        if (c >= 8'h20) begin
            scr[mr * 80 + mc] = c;
            if (mc < 79) mc++;
            else begin
                mc = 0;
                if (mr < 29) mr++; else model_scroll();
            end
        end else if (c == 8'h0A) begin
            mc = 0;
            if (mr < 29) mr++; else model_scroll();
        end else if (c == 8'h0D) mc = 0;
        else if (c == 8'h08) begin
            if (mc > 0) begin
                mc--;
                scr[mr * 80 + mc] = 8'h20;
            end
        end else if (c == 8'h0C) begin
            for (int i = 0; i < 2400; i++) scr[i] = 8'h20;
            mr = 0;
            mc = 0;
        end
    endtask
    function automatic logic [7:0] rnd_print();
        return 8'($urandom_range(32, 255));
    endfunction
    task automatic send(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        bus.char_in = c;
        bus.char_valid = 1'b1;
        while (!bus.char_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) chk("send_timeout", 32'(bus.char_ready), 1);
        @(negedge clk);
        acc_cyc = cyc;
        bus.char_valid = 1'b0;
    endtask
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(bus.char_ready && !bus.busy) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) chk("idle_timeout", 32'(bus.char_ready), 1);
    endtask
    task automatic put(input logic [7:0] c);
        send(c);
        wait_idle();
        model_char(c);
    endtask
    task automatic chk_cursor(input string tag, input int r, input int c);
        chk({tag, "_row"}, 32'(bus.cursor_row), r);
        chk({tag, "_col"}, 32'(bus.cursor_col), c);
    endtask
    task automatic chk_screen(input string tag);
        int n = 0;
        for (int i = 0; i < 2400; i++) if (mem[i] !== scr[i]) n++;
        chk(tag, n, 0);
    endtask
    initial begin
        int l0, b0, err, n, acc2;
        logic [7:0] c;
        bus.char_in = 8'h00;
        bus.char_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.char_ready), 0);
        chk("rst_we", 32'(bus.vram_we), 0);
        chk("rst_waddr", 32'(bus.vram_waddr), 0);
        chk("rst_raddr", 32'(bus.vram_raddr), 0);
        chk("rst_wdata", 32'(bus.vram_wdata), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk_cursor("rst", 0, 0);
        clrn = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(bus.char_ready), 1);
        l0 = lg_addr.size();
        send(8'h41);
        chk("a_ready_put", 32'(bus.char_ready), 0);
        chk_cursor("a", 0, 1);
        @(negedge clk);
        chk("a_ready_next", 32'(bus.char_ready), 1);
        chk("a_nwrites", lg_addr.size() - l0, 1);
        chk("a_addr", lg_addr[l0], 0);
        chk("a_data", lg_data[l0], 32'h41);
        chk("a_cycle", lg_cyc[l0], acc_cyc);
        model_char(8'h41);
        put(8'h0C);
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(0, 9);
            c = rnd_print();
            if (n == 0) c = 8'h0A;
            if (n == 1) c = 8'h0D;
            if (n == 2) c = 8'h08;
            if (n == 3) begin
                c = 8'($urandom_range(0, 31));
                if (c == 8'h0A || c == 8'h0D || c == 8'h08 || c == 8'h0C) c = 8'h01;
            end
            put(c);
            chk_cursor("rnd", mr, mc);
        end
        chk_screen("rnd_screen");
        put(8'h0C);
        repeat (3) put(8'h0A);
        repeat (79) put(rnd_print());
        chk_cursor("pos_3_79", 3, 79);
        l0 = lg_addr.size();
        b0 = busy_cyc;
        put(8'h5A);
        chk("z_nwrites", lg_addr.size() - l0, 1);
        chk("z_addr", lg_addr[l0], 319);
        chk("z_data", lg_data[l0], 32'h5A);
        chk("z_no_busy", busy_cyc - b0, 0);
        chk_cursor("z", 4, 0);
        put(8'h0C);
        repeat (29 * 80 + 5) put(rnd_print());
        chk_cursor("pos_29_5", 29, 5);
        for (int i = 0; i < 2400; i++) pre[i] = scr[i];
        l0 = lg_addr.size();
        b0 = busy_cyc;
        put(8'h0A);
        chk("scroll_busy_cycles", busy_cyc - b0, 2401);
        chk("scroll_nwrites", lg_addr.size() - l0, 2400);
        err = 0;
        for (int i = 0; i < 2400 && l0 + i < lg_addr.size(); i++)
            if (lg_addr[l0 + i] != i || lg_cyc[l0 + i] != acc_cyc + 1 + i ||
                lg_data[l0 + i] != int'(i < 2320 ? pre[i + 80] : 8'h20)) err++;
        chk("scroll_write_seq", err, 0);
        chk_cursor("scroll", 29, 0);
        chk("scroll_ready", 32'(bus.char_ready), 1);
        chk_screen("scroll_screen");
        put(8'h0C);
        repeat (7) put(8'h0A);
        l0 = lg_addr.size();
        put(8'h08);
        chk("bs0_nwrites", lg_addr.size() - l0, 0);
        chk_cursor("bs0", 7, 0);
        repeat (10) put(rnd_print());
        l0 = lg_addr.size();
        put(8'h08);
        chk("bs_nwrites", lg_addr.size() - l0, 1);
        chk("bs_addr", lg_addr[l0], 569);
        chk("bs_data", lg_data[l0], 32'h20);
        chk_cursor("bs", 7, 9);
        l0 = lg_addr.size();
        b0 = busy_cyc;
        send(8'h0C);
        bus.char_in = 8'h78;
        bus.char_valid = 1'b1;
        n = 0;
        while (!bus.char_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("ff_ready_cycle", cyc - acc_cyc, 2400);
        chk("ff_busy_at_accept", 32'(bus.busy), 0);
        @(negedge clk);
        acc2 = cyc;
        bus.char_valid = 1'b0;
        wait_idle();
        model_char(8'h0C);
        model_char(8'h78);
        chk("ff_busy_cycles", busy_cyc - b0, 2400);
        chk("ff_nwrites", lg_addr.size() - l0, 2401);
        err = 0;
        for (int i = 0; i < 2400 && l0 + i < lg_addr.size(); i++)
            if (lg_addr[l0 + i] != i || lg_data[l0 + i] != 32'h20) err++;
        chk("ff_write_seq", err, 0);
        chk("x_addr", lg_addr[l0 + 2400], 0);
        chk("x_data", lg_data[l0 + 2400], 32'h78);
        chk("x_cycle", lg_cyc[l0 + 2400], acc2);
        chk_cursor("x", 0, 1);
        chk_screen("ff_screen");
        repeat (29) put(8'h0A);
        chk_cursor("pre_rst", 29, 0);
        send(8'h0A);
        repeat (100) @(negedge clk);
        chk("rst_mid_busy", 32'(bus.busy), 1);
        #2 clrn = 1'b0;
        #1;
        chk("arst_we", 32'(bus.vram_we), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_ready", 32'(bus.char_ready), 0);
        chk_cursor("arst", 0, 0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        chk("post_ready", 32'(bus.char_ready), 1);
        chk("post_busy", 32'(bus.busy), 0);
        chk("post_we", 32'(bus.vram_we), 0);
        l0 = lg_addr.size();
        send(8'h51);
        wait_idle();
        chk("q_nwrites", lg_addr.size() - l0, 1);
        chk("q_addr", lg_addr[l0], 0);
        chk("q_data", lg_data[l0], 32'h51);
        chk("no_ready_while_busy", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
